// File: rtl/opl_timer_bank.sv
// OPL-compatible interval timer bank: up to three 8-bit up-counting timers on
// power-of-two multiples of a shared base tick, with latched flags and an IRQ.
module opl_timer_bank #(
    parameter int unsigned NUM_TIMERS       = 2,
    parameter int unsigned BASE_TICK_CYCLES = 1018,
    parameter int unsigned PRESCALE_SHIFT   = 2,
    parameter logic [7:0]  TIMER_BASE_ADDR  = 8'h02,
    parameter logic [7:0]  CTRL_ADDR        = 8'h04
) (
    input  logic        clk,
    input  logic        ic_n,
    input  logic [17:0] opl3_reg_wr,
    input  logic        force_timer_overflow,
    output logic [7:0]  status,
    output logic        irq_n
);

    localparam int unsigned PW     = (BASE_TICK_CYCLES > 1) ? $clog2(BASE_TICK_CYCLES) : 1;
    localparam int unsigned SW_RAW = (NUM_TIMERS - 1) * PRESCALE_SHIFT;
    localparam int unsigned SW     = (SW_RAW == 0) ? 1 : SW_RAW;
    localparam logic [PW-1:0] PRESC_LAST = PW'(BASE_TICK_CYCLES - 1);

    logic [PW-1:0]         presc;
    logic [SW-1:0]         sub;
    logic                  base_tick;
    logic [NUM_TIMERS-1:0] tick;

    logic       wr_en, ctrl_wr, ctrl_set, irq_clr;
    logic [7:0] wr_addr, wr_data;

    logic [7:0]            preset  [NUM_TIMERS];
    logic [7:0]            counter [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] start, mask, flag, set_flag;

    // Ones in the low idx*PRESCALE_SHIFT bits; empty for timer 0.
    function automatic logic [SW-1:0] low_mask(input int unsigned idx);
        logic [SW:0] m;
        m = ((SW+1)'(1) << (idx * PRESCALE_SHIFT)) - (SW+1)'(1);
        return m[SW-1:0];
    endfunction

    assign base_tick = (presc == PRESC_LAST);

    always_ff @(posedge clk or negedge ic_n) begin
        if (!ic_n) begin
            presc <= '0;
            sub   <= '0;
        end else begin
            presc <= base_tick ? '0 : presc + 1'b1;
            if (base_tick) begin
                sub <= sub + 1'b1;
            end
        end
    end

    always_comb begin
        tick = '0;
        for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
            tick[i] = base_tick && ((sub & low_mask(i)) == low_mask(i));
        end
    end

    assign wr_en    = opl3_reg_wr[17] & ~opl3_reg_wr[16];
    assign wr_addr  = opl3_reg_wr[15:8];
    assign wr_data  = opl3_reg_wr[7:0];
    assign ctrl_wr  = wr_en && (wr_addr == CTRL_ADDR);
    assign irq_clr  = ctrl_wr & wr_data[7];
    assign ctrl_set = ctrl_wr & ~wr_data[7];

    always_comb begin
        set_flag = '0;
        for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
            set_flag[i] = ((start[i] && tick[i] && (counter[i] == 8'hFF)) ||
                           force_timer_overflow) && !mask[i];
        end
    end

    always_ff @(posedge clk or negedge ic_n) begin
        if (!ic_n) begin
            start <= '0;
            mask  <= '0;
            flag  <= '0;
            for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
                preset[i]  <= '0;
                counter[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
                if (wr_en && (wr_addr == 8'(TIMER_BASE_ADDR + i))) begin
                    preset[i] <= wr_data;
                end
                if (ctrl_set) begin
                    start[i] <= wr_data[i];
                    mask[i]  <= wr_data[6-i];
                end
                // A rising start reloads; a running timer never sees it, so the two cannot collide.
                if (ctrl_set && wr_data[i] && !start[i]) begin
                    counter[i] <= preset[i];
                end else if (start[i] && tick[i]) begin
                    counter[i] <= (counter[i] == 8'hFF) ? preset[i] : counter[i] + 8'd1;
                end
                if (set_flag[i]) begin
                    flag[i] <= 1'b1;
                end else if (irq_clr) begin
                    flag[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        status = '0;
        for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
            status[6-i] = flag[i];
        end
        status[7] = |flag;
    end

    assign irq_n = ~status[7];

endmodule

// File: doc/opl_timer_bank.md
# opl_timer_bank

Parametrised OPL-compatible interval timer block: 1 to 3 independent 8-bit up-counting timers, each clocked by its own power-of-two multiple of a shared base tick, with per-timer start and mask, latched overflow flags, a status byte and an active-low IRQ. It sits beside `host_if` and `channels` in the synth top level. It decodes the same 18-bit register-write bus, returns the status byte to `host_if` for status reads, and replaces the fixed two-timer block with one generalised in count, tick rate and prescale.

## Interface
- NUM_TIMERS, 2, number of timers (legal 1..3)
- BASE_TICK_CYCLES, 1018, clk cycles per base tick (80 us at 12.727 MHz); legal >= 2
- PRESCALE_SHIFT, 2, timer i ticks once per 2^(i*PRESCALE_SHIFT) base ticks
- TIMER_BASE_ADDR, 8'h02, bank-0 address of timer 0 preset; timer i preset at TIMER_BASE_ADDR+i
- CTRL_ADDR, 8'h04, bank-0 address of control register
- clk  in  1  system clock, single clock domain
- ic_n  in  1  asynchronous active-low reset
- opl3_reg_wr  in  18  register write: [17] valid, [16] bank, [15:8] address, [7:0] data
- force_timer_overflow  in  1  one-cycle pulse from host_if test hook
- status  out  8  [7] IRQ, [6-i] flag of timer i, all other bits 0
- irq_n  out  1  low while any flag is set

## Operation
- Prescaler: free-running counter 0..BASE_TICK_CYCLES-1. base_tick pulses for one cycle on wrap. Sub-counter of width (NUM_TIMERS-1)*PRESCALE_SHIFT (min 1) increments on base_tick. tick_i = base_tick AND low i*PRESCALE_SHIFT sub-counter bits all ones; tick_0 = base_tick.
- Writes are decoded only when valid=1 and bank=0. Bank-1 writes and unmapped addresses are ignored.
- Preset write (TIMER_BASE_ADDR+i, i<NUM_TIMERS): preset_i <= data. A running counter is not reloaded and picks up the new preset on its next reload.
- Control write, data[7]=1: IRQ reset. All flags clear and all other data bits are ignored.
- Control write, data[7]=0: mask_i <= data[6-i], start_i <= data[i].
- start_i 0->1: counter_i <= preset_i. start_i 1->0: counter_i holds. start_i 1->1: no reload.
- Running timer on tick_i: if counter_i==8'hFF, overflow: counter_i <= preset_i, and flag_i <= 1 unless mask_i. Otherwise counter_i increments.
- Period = (256-preset) ticks. Preset 8'hFF gives an overflow every tick.
- force_timer_overflow sets flag_i for every unmasked timer, running or not. Counters are untouched.
- Masking never clears an existing flag. Only IRQ reset clears flags.
- Simultaneous IRQ reset and flag set in the same cycle: the set wins, so the flag is 1 afterwards.
- status[7] = OR of flags. irq_n = NOT status[7]. Both are combinational from registered flags, with no further logic.

## Timing
- Reset (ic_n low, async): prescaler, sub-counter, counters, presets, start, mask and flags all 0. status = 8'h00, irq_n = 1. The first base_tick occurs BASE_TICK_CYCLES cycles after release.
- Write accepted at edge n: registers are updated at edge n and visible from cycle n+1. A start written at n can count on a tick at n+1 or later.
- Overflow on the tick at edge n: the flag is set at edge n, so status and irq_n change in cycle n+1.
- IRQ reset at edge n: status = 8'h00 and irq_n = 1 from cycle n+1, unless an overflow or force occurred at edge n.
- Reset asserted mid-count abandons all state immediately. No partial write survives.

## Test plan
- Reset: hold ic_n low, write traffic active -> status 8'h00, irq_n 1. After release, no flag appears with all timers stopped for 10 base ticks.
- BASE_TICK_CYCLES=4: preset0=8'hFE, ctrl=8'h01 -> status 8'hC0 and irq_n 0 exactly 2 base ticks after start. IRQ reset 8'h80 clears it, and the flag re-asserts 2 ticks later (reload checked).
- NUM_TIMERS=2, PRESCALE_SHIFT=2, preset1=8'hFF, ctrl=8'h02 -> status 8'hA0 at every 4th base tick only.
- ctrl=8'h41, preset0=8'hFF -> counter wraps but status stays 8'h00 and irq_n stays 1. Force pulse with ctrl=8'h40 -> status 8'hA0.
- IRQ reset write landing on the same edge as a timer-0 overflow -> status 8'hC0 on the next cycle.
- Bank-1 write of 8'h01 to 8'h04 and of 8'hFF to 8'h02 -> no start, no preset change, status 8'h00.
